serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller that computes `d = a - b - bin` for WIDTH-bit operands. It reuses one full-subtractor cell, driving it LSB first, one bit per clock, and holds the borrow between cycles in a register. It sits between a requester that presents operands under a start/done handshake and the single-bit full-subtractor datapath. It trades WIDTH cycles of latency for one cell's worth of logic.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  minuend; captured on the accepted start edge
- `b`  in  WIDTH  subtrahend; captured on the accepted start edge
- `bin`  in  1  initial borrow-in; captured on the accepted start edge
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse when the result is committed
- `d`  out  WIDTH  difference; registered, holds the last committed result
- `bout`  out  1  final borrow; registered, holds the last committed value

One clock; reset is synchronous and active-high.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: WIDTH bit-cycles.
  - DONE: one cycle, commits the result.
- IDLE:
  - If `start`=1 at an edge, load `a` and `b` into shift registers `sa` and `sb`.
  - Load `bin` into borrow register `br`, clear bit counter `cnt`, clear accumulator `acc`, and go to RUN.
  - If `start`=0, stay in IDLE.
- RUN, at each edge:
  - Cell inputs are `sa[0]`, `sb[0]` and `br`.
  - Cell difference = a^b^br. Cell borrow = (~a&b) | (~(a^b)&br).
  - Shift `acc` right, inserting the cell difference at the MSB.
  - Shift `sa` and `sb` right, load `br` with the cell borrow, and increment `cnt`.
  - When `cnt`=WIDTH-1 at the edge, this is the last bit; go to DONE.
- DONE, at its edge:
  - `d` ← `acc`, `bout` ← `br`, `done` ← 1 for exactly one cycle.
  - Go to IDLE.
- Start outside IDLE:
  - `start` in RUN or DONE is ignored and not queued.
  - The requester must re-assert it after `done`.
- Registered outputs: `d` and `bout` change only on the DONE commit, never mid-run.
- Operand stability: operands may change freely after the accepted edge.
- Arithmetic: modulo 2^WIDTH. `bout`=1 iff a < b + bin as unsigned values.
- Reset:
  - `rst`=1 at any edge, including mid-RUN, forces IDLE.
  - Clears `busy`, `done`, `d`, `bout`, `br`, `cnt`, `acc`, `sa` and `sb` to 0.
  - The aborted operation produces no `done`.
- Reset priority: `rst` and `start` together give reset.

## Timing
- Reset values: `busy`=0, `done`=0, `d`=0, `bout`=0, state IDLE.
- Accepted start at edge E0:
  - `busy`=1 from after E0 through the edge that processes the last bit (E0+WIDTH).
  - That last edge lowers `busy`.
- Commit:
  - The commit edge is E0+WIDTH+1.
  - After it, `done`=1 and `d`/`bout` are valid.
  - `done` falls after E0+WIDTH+2.
- Latency: start-to-done is WIDTH+1 edges, 9 for WIDTH=8.
- Earliest next start: sampled at E0+WIDTH+2, i.e. the cycle in which `done` is high and the state is IDLE.
- Throughput: one operation per WIDTH+2 cycles.

## Structure
- Shared package `fs_pkg`:
  - State typedef with encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Localparam `CNT_W` = $clog2(WIDTH).
- Sub-module `fs_cell` holds the combinational full subtractor.
  - Ports: `a`, `b`, `cin` → `d`, `cout`.
  - Instantiated once; the controller holds all sequential state.
- Unused state encoding 2'd3 returns to IDLE.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse → `done` 9 edges later; d=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → d=0xFE, bout=1. a=0x00, b=0x00, bin=1 → d=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=1 → d=0xFF, bout=1. a=0x80, b=0x01, bin=0 → d=0x7F, bout=0.
- Second start asserted 3 cycles into RUN with different operands → ignored; first result is delivered, and exactly one `done` pulse occurs.
- `rst` asserted 4 cycles into RUN → next cycle all outputs are 0 and state is IDLE; no `done`; a following request completes correctly.
- Back-to-back: start held high continuously → one operation every 10 edges; `d` stays stable between commits and never shows partial values.

Source files
------------

// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - shared types and constants for the bit-serial subtractor
package fs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fs_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - requester <-> subtractor start/done handshake
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
endinterface

// File: rtl/fs_cell.sv
// rtl/fs_cell.sv - single-bit combinational full subtractor
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic cout
);
    assign d    = a ^ b ^ cin;
    assign cout = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - computes d = a - b - bin one bit per clock, LSB first
module serial_sub_ctrl
    import fs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    fs_state_t        state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             cell_d;
    logic             cell_b;

    fs_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (br),
        .d    (cell_d),
        .cout (cell_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            d_r    <= '0;
            bout_r <= 1'b0;
            br     <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            sa     <= '0;
            sb     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // start is only honoured here, so requests during RUN/DONE are dropped
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        br     <= bus.bin;
                        cnt    <= '0;
                        acc    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= {cell_d, acc[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= cell_b;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    d_r    <= acc;
                    bout_r <= br;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.d, bus.bout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b d=%02h bout=%0b, required all 0",
                     bus.busy, bus.done, bus.d, bus.bout);
        end
        rst = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] exp_d, input logic exp_bout);
        logic [7:0] d_prev;
        int         n;
        @(negedge clk);
        d_prev    = bus.d;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = 8'h5A;
        bus.bin   = ~bin;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%0b, required 1", bus.busy);
        end
        n = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (bus.done === 1'b1) break;
            if (bus.d !== d_prev) begin
                checks++;
                errors++;
                $display("FAIL d_midrun: d=%02h at edge %0d, required held %02h", bus.d, i, d_prev);
            end
        end
        checks++;
        if (n != WIDTH + 1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL latency: done=%0b after %0d edges, required done=1 after %0d", bus.done, n, WIDTH + 1);
        end
        checks++;
        if (bus.d !== exp_d || bus.bout !== exp_bout) begin
            errors++;
            $display("FAIL result %02h-%02h-%0b: d=%02h bout=%0b, required d=%02h bout=%0b",
                     a, b, bin, bus.d, bus.bout, exp_d, exp_bout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%0b busy=%0b one edge later, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_vectors();
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    endtask

    task automatic test_ignored_start();
        int dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            // second request with different operands, raised then dropped inside RUN
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h40;
                bus.b     = 8'h11;
                bus.bin   = 1'b1;
            end
            if (i == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                checks++;
                if (bus.d !== 8'h02 || bus.bout !== 1'b0 || i != WIDTH + 1) begin
                    errors++;
                    $display("FAIL ignored_start_result: d=%02h bout=%0b at edge %0d, required 02 0 at edge %0d",
                             bus.d, bus.bout, i, WIDTH + 1);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignored_start_dones: %0d done pulses, required 1", dones);
        end
    endtask

    task automatic test_reset_midrun();
        int dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h03;
        bus.b     = 8'h05;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.d, bus.bout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%0b done=%0b d=%02h bout=%0b, required all 0",
                     bus.busy, bus.done, bus.d, bus.bout);
        end
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles with done/busy after reset, required 0", dones);
        end
        run_op(8'h10, 8'h04, 1'b0, 8'h0C, 1'b0);
    endtask

    task automatic test_back_to_back();
        int         ndone;
        int         last;
        logic [7:0] exp_d;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h20;
        bus.b     = 8'h05;
        bus.bin   = 1'b0;
        ndone = 0;
        last  = 0;
        exp_d = 8'h0C;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                ndone++;
                exp_d = 8'h1B;
                checks++;
                if (i - last != WIDTH + 2) begin
                    errors++;
                    $display("FAIL b2b_interval: done at edge %0d, previous %0d, required spacing %0d",
                             i, last, WIDTH + 2);
                end
                last = i;
            end
            if (bus.d !== exp_d) begin
                checks++;
                errors++;
                $display("FAIL b2b_d_stable: d=%02h at edge %0d, required %02h", bus.d, i, exp_d);
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 4 || bus.bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: %0d commits bout=%0b, required 4 commits bout=0", ndone, bus.bout);
        end
        repeat (12) @(posedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_ignored_start();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
